// File: rtl/pad_event_arbiter_pkg.sv
// Shared types and helpers for the dance-pad event arbiter.
// Optional timestamp feature is controlled by the PAD_EVT_TIMESTAMP_EN macro.
package ddr_pad_pkg;

    typedef enum logic [1:0] {
        LS_IDLE,
        LS_PRESS,
        LS_HELD
    } lane_state_t;

    localparam int PAD_LANES_DEFAULT = 4;

    // Lane index reached by stepping 'off' positions past 'base', wrapping at 'lanes'.
    function automatic int rr_index(input int base, input int off, input int lanes);
        return (base + off) % lanes;
    endfunction

endpackage

// File: rtl/pad_event_arbiter_if.sv
// Valid/ready event stream from the pad arbiter to the hit-judging logic.
// evt_ts is present only when PAD_EVT_TIMESTAMP_EN is defined.
interface pad_event_arbiter_if #(
    parameter int LANES = 4,
    parameter int TS_W  = 16
);
    localparam int LANE_W = $clog2(LANES);

    logic              evt_valid;
    logic              evt_ready;
    logic [LANE_W-1:0] evt_lane;
`ifdef PAD_EVT_TIMESTAMP_EN
    logic [TS_W-1:0]   evt_ts;

    modport master (output evt_valid, output evt_lane, output evt_ts, input evt_ready);
    modport slave  (input evt_valid, input evt_lane, input evt_ts, output evt_ready);
`else
    modport master (output evt_valid, output evt_lane, input evt_ready);
    modport slave  (input evt_valid, input evt_lane, output evt_ready);
`endif

endinterface

// File: rtl/pad_event_arbiter_lane_fsm.sv
// Per-lane press detector with a one-deep pending event slot and drop flag.
// Exposes a capture strobe only when PAD_EVT_TIMESTAMP_EN is defined.
//
//  state    | meaning
//  ---------+---------------------------------------------------
//  LS_IDLE  | button released, waiting for a press
//  LS_PRESS | first cycle the button is seen high (press strobe)
//  LS_HELD  | button still held, no further events
module pad_lane_fsm
    import ddr_pad_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic grant,
    output logic pending,
    output logic drop
`ifdef PAD_EVT_TIMESTAMP_EN
    ,
    output logic capture
`endif
);

    lane_state_t state, state_nxt;
    logic        press;
    logic        pending_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= LS_IDLE;
            pending <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LS_IDLE:  if (btn) state_nxt = LS_PRESS;
            LS_PRESS: state_nxt = btn ? LS_HELD : LS_IDLE;
            LS_HELD:  if (!btn) state_nxt = LS_IDLE;
            default:  state_nxt = LS_IDLE;
        endcase
    end

    // A press arriving while the old event is being granted replaces it.
    assign press       = (state == LS_PRESS);
    assign pending_nxt = grant ? press : (pending | press);
    assign drop        = press & pending & ~grant;
`ifdef PAD_EVT_TIMESTAMP_EN
    assign capture     = press & (~pending | grant);
`endif

endmodule

// File: rtl/pad_event_arbiter.sv
// Round-robin arbiter serialising per-lane pad presses onto one valid/ready stream.
// Define PAD_EVT_TIMESTAMP_EN to add a free-running press timestamp (evt_ts).
module pad_event_arbiter
    import ddr_pad_pkg::*;
#(
    parameter  int LANES  = PAD_LANES_DEFAULT,
    parameter  int TS_W   = 16,
    localparam int LANE_W = $clog2(LANES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [LANES-1:0]     btn,
    pad_event_arbiter_if.master  evt,
    output logic                 ovf,
    input  logic                 clr_ovf
);

    logic [LANES-1:0]  pending;
    logic [LANES-1:0]  drop;
    logic [LANES-1:0]  grant;
    logic [LANE_W-1:0] rr_ptr;
    logic [LANE_W-1:0] winner;
    logic              found;
    logic              load;

`ifdef PAD_EVT_TIMESTAMP_EN
    logic [LANES-1:0]  capture;
    logic [TS_W-1:0]   ts_cnt;
    logic [TS_W-1:0]   ts_reg [LANES];
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pad_lane_fsm u_lane (
            .clk     (clk),
            .reset   (reset),
            .btn     (btn[i]),
            .grant   (grant[i]),
            .pending (pending[i]),
            .drop    (drop[i])
`ifdef PAD_EVT_TIMESTAMP_EN
            ,
            .capture (capture[i])
`endif
        );
    end

    assign load = !evt.evt_valid || evt.evt_ready;

    // Search starts just after the last winner so every lane gets a fair turn.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        grant  = '0;
        for (int off = 1; off <= LANES; off++) begin
            if (!found && pending[rr_index(int'(rr_ptr), off, LANES)]) begin
                found  = 1'b1;
                winner = LANE_W'(rr_index(int'(rr_ptr), off, LANES));
            end
        end
        if (load && found) grant[winner] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            evt.evt_valid <= 1'b0;
            evt.evt_lane  <= '0;
            rr_ptr        <= LANE_W'(LANES - 1);
        end else if (load) begin
            evt.evt_valid <= found;
            if (found) begin
                evt.evt_lane <= winner;
                rr_ptr       <= winner;
            end
        end
    end

    // A drop in the same cycle as a clear must stay visible.
    always_ff @(posedge clk) begin
        if (reset)           ovf <= 1'b0;
        else if (|drop)      ovf <= 1'b1;
        else if (clr_ovf)    ovf <= 1'b0;
    end

`ifdef PAD_EVT_TIMESTAMP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt     <= '0;
            evt.evt_ts <= '0;
            for (int i = 0; i < LANES; i++) ts_reg[i] <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            for (int i = 0; i < LANES; i++) begin
                if (capture[i]) ts_reg[i] <= ts_cnt;
            end
            if (load && found) evt.evt_ts <= ts_reg[winner];
        end
    end
`endif

endmodule
